// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling and a one-byte
// output buffer that reports framing errors and overruns as single-cycle pulses.
module uart_receiver #(
   parameter int unsigned CLK_FREQ_HZ = 100000000,
   parameter int unsigned BAUD_RATE   = 115200
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx,
   output logic [7:0] read_data,
   output logic       read_valid,
   input  logic       read_ack,
   output logic       framing_error,
   output logic       overrun
);

   localparam int unsigned BitPeriod  = CLK_FREQ_HZ / BAUD_RATE;
   localparam int unsigned HalfPeriod = BitPeriod / 2;
   localparam int unsigned TimerW     = (BitPeriod > 1) ? $clog2(BitPeriod) : 1;
   localparam logic [TimerW-1:0] BitLast  = TimerW'(BitPeriod - 1);
   localparam logic [TimerW-1:0] HalfLast = TimerW'(HalfPeriod - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitIdle
   } state_e;

   logic              rx_meta_q, rx_s_q;
   state_e            state_q, state_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        read_data_q, read_data_d;
   logic              read_valid_q, read_valid_d;
   logic              framing_error_q, framing_error_d;
   logic              overrun_q, overrun_d;
   logic              deliver;
   logic              frame_err;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_meta_q       <= 1'b1;
         rx_s_q          <= 1'b1;
         state_q         <= StIdle;
         timer_q         <= '0;
         bit_idx_q       <= '0;
         shift_q         <= '0;
         read_data_q     <= '0;
         read_valid_q    <= 1'b0;
         framing_error_q <= 1'b0;
         overrun_q       <= 1'b0;
      end else begin
         rx_meta_q       <= rx;
         rx_s_q          <= rx_meta_q;
         state_q         <= state_d;
         timer_q         <= timer_d;
         bit_idx_q       <= bit_idx_d;
         shift_q         <= shift_d;
         read_data_q     <= read_data_d;
         read_valid_q    <= read_valid_d;
         framing_error_q <= framing_error_d;
         overrun_q       <= overrun_d;
      end
   end

   // Timer restarts from zero on every state change and after every data-bit sample.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q + TimerW'(1);
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      deliver   = 1'b0;
      frame_err = 1'b0;
      case (state_q)
         StIdle: begin
            timer_d = '0;
            if (!rx_s_q) state_d = StStart;
         end
         StStart: begin
            if (timer_q == HalfLast) begin
               timer_d   = '0;
               bit_idx_d = '0;
               state_d   = rx_s_q ? StIdle : StData;
            end
         end
         StData: begin
            if (timer_q == BitLast) begin
               timer_d           = '0;
               shift_d[bit_idx_q] = rx_s_q;
               bit_idx_d         = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = StStop;
            end
         end
         StStop: begin
            if (timer_q == BitLast) begin
               timer_d = '0;
               if (rx_s_q) begin
                  deliver = 1'b1;
                  state_d = StIdle;
               end else begin
                  frame_err = 1'b1;
                  state_d   = StWaitIdle;
               end
            end
         end
         StWaitIdle: begin
            timer_d = '0;
            if (rx_s_q) state_d = StIdle;
         end
         default: begin
            timer_d = '0;
            state_d = StIdle;
         end
      endcase
   end

   // A consume and a delivery in the same cycle hand the buffer straight to the new byte.
   always_comb begin
      read_data_d     = read_data_q;
      read_valid_d    = read_valid_q;
      framing_error_d = frame_err;
      overrun_d       = 1'b0;
      if (read_valid_q && read_ack) read_valid_d = 1'b0;
      if (deliver) begin
         if (read_valid_q && !read_ack) begin
            overrun_d = 1'b1;
         end else begin
            read_data_d  = shift_q;
            read_valid_d = 1'b1;
         end
      end
   end

   assign read_data     = read_data_q;
   assign read_valid    = read_valid_q;
   assign framing_error = framing_error_q;
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 100 MHz / 115200 baud (868 cycles per bit).
module tb_uart_receiver;

   localparam int P   = 868;
   localparam int H   = 434;
   // Posedges after the start-bit falling edge until the delivery edge: 2 sync + 1 + H + 9P.
   localparam int DLV = 3 + H + 9 * P;

   logic       clk;
   logic       reset_n;
   logic       rx;
   logic [7:0] read_data;
   logic       read_valid;
   logic       read_ack;
   logic       framing_error;
   logic       overrun;

   int n_cmp  = 0;
   int n_fail = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;

   uart_receiver #(
      .CLK_FREQ_HZ(100000000),
      .BAUD_RATE  (115200)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .rx           (rx),
      .read_data    (read_data),
      .read_valid   (read_valid),
      .read_ack     (read_ack),
      .framing_error(framing_error),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters: one cycle per event, so the count equals events only for 1-cycle pulses.
   always @(negedge clk) begin
      if (framing_error === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
   end

   // Called at a negedge; returns at a negedge.
   task automatic send_frame(input logic [7:0] b, input int per, input logic stop_bit);
      rx = 1'b0;
      repeat (per) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (per) @(negedge clk);
      end
      rx = stop_bit;
      repeat (per) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic consume();
      read_ack = 1'b1;
      @(negedge clk);
      read_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      rx       = 1'b1;
      read_ack = 1'b0;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (read_data !== 8'h00) begin
         n_fail++; $display("FAIL reset_read_data got %h want 00", read_data);
      end
      n_cmp++;
      if (read_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_read_valid got %b want 0", read_valid);
      end
      n_cmp++;
      if (framing_error !== 1'b0 || overrun !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags got fe=%b ov=%b want 0 0", framing_error, overrun);
      end
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_basic();
      logic pre_valid, post_valid;
      logic [7:0] post_data;
      fork
         send_frame(8'hA5, P, 1'b1);
         begin
            repeat (DLV - 1) @(posedge clk);
            @(negedge clk);
            pre_valid = read_valid;
            @(negedge clk);
            post_valid = read_valid;
            post_data  = read_data;
         end
      join
      n_cmp++;
      if (pre_valid !== 1'b0) begin
         n_fail++; $display("FAIL basic_early_valid got %b want 0", pre_valid);
      end
      n_cmp++;
      if (post_valid !== 1'b1) begin
         n_fail++; $display("FAIL basic_delivery_edge got %b want 1", post_valid);
      end
      n_cmp++;
      if (post_data !== 8'hA5) begin
         n_fail++; $display("FAIL basic_data got %h want a5", post_data);
      end
      n_cmp++;
      if (read_valid !== 1'b1 || read_data !== 8'hA5) begin
         n_fail++; $display("FAIL basic_hold got v=%b d=%h want 1 a5", read_valid, read_data);
      end
      consume();
      n_cmp++;
      if (read_valid !== 1'b0) begin
         n_fail++; $display("FAIL basic_ack_clear got %b want 0", read_valid);
      end
      // Ack while nothing is buffered must not disturb anything.
      consume();
      n_cmp++;
      if (read_valid !== 1'b0 || read_data !== 8'hA5) begin
         n_fail++; $display("FAIL idle_ack got v=%b d=%h want 0 a5", read_valid, read_data);
      end
   endtask

   task automatic test_glitch();
      int fe0 = fe_cnt;
      int ov0 = ov_cnt;
      rx = 1'b0;
      repeat (200) @(negedge clk);
      rx = 1'b1;
      repeat (600) @(negedge clk);
      n_cmp++;
      if (read_valid !== 1'b0) begin
         n_fail++; $display("FAIL glitch_valid got %b want 0", read_valid);
      end
      n_cmp++;
      if (fe_cnt != fe0 || ov_cnt != ov0) begin
         n_fail++; $display("FAIL glitch_flags got fe=%0d ov=%0d want 0 0", fe_cnt - fe0,
                            ov_cnt - ov0);
      end
      send_frame(8'h3C, P, 1'b1);
      n_cmp++;
      if (read_valid !== 1'b1 || read_data !== 8'h3C) begin
         n_fail++; $display("FAIL glitch_next got v=%b d=%h want 1 3c", read_valid, read_data);
      end
      consume();
   endtask

   task automatic test_framing();
      int fe0 = fe_cnt;
      int ov0 = ov_cnt;
      send_frame(8'h55, P, 1'b0);
      rx = 1'b0;
      repeat (5000) @(negedge clk);
      n_cmp++;
      if (fe_cnt - fe0 != 1) begin
         n_fail++; $display("FAIL framing_pulse got %0d want 1", fe_cnt - fe0);
      end
      n_cmp++;
      if (read_valid !== 1'b0) begin
         n_fail++; $display("FAIL framing_valid got %b want 0", read_valid);
      end
      rx = 1'b1;
      repeat (3500) @(negedge clk);
      n_cmp++;
      if (read_valid !== 1'b0 || fe_cnt - fe0 != 1 || ov_cnt != ov0) begin
         n_fail++; $display("FAIL framing_no_restart got v=%b fe=%0d ov=%0d want 0 1 0",
                            read_valid, fe_cnt - fe0, ov_cnt - ov0);
      end
   endtask

   task automatic test_back_to_back();
      int ov0 = ov_cnt;
      send_frame(8'h11, P, 1'b1);
      send_frame(8'h22, P, 1'b1);
      n_cmp++;
      if (read_valid !== 1'b1 || read_data !== 8'h11) begin
         n_fail++; $display("FAIL overrun_keep got v=%b d=%h want 1 11", read_valid, read_data);
      end
      n_cmp++;
      if (ov_cnt - ov0 != 1) begin
         n_fail++; $display("FAIL overrun_pulse got %0d want 1", ov_cnt - ov0);
      end
      ov0 = ov_cnt;
      fork
         send_frame(8'h22, P, 1'b1);
         begin
            repeat (DLV - 1) @(posedge clk);
            @(negedge clk);
            read_ack = 1'b1;
            @(negedge clk);
            read_ack = 1'b0;
         end
      join
      n_cmp++;
      if (read_valid !== 1'b1 || read_data !== 8'h22) begin
         n_fail++; $display("FAIL ack_same_cycle got v=%b d=%h want 1 22", read_valid, read_data);
      end
      n_cmp++;
      if (ov_cnt != ov0) begin
         n_fail++; $display("FAIL ack_same_cycle_overrun got %0d want 0", ov_cnt - ov0);
      end
      consume();
      n_cmp++;
      if (read_valid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_consume got %b want 0", read_valid);
      end
   endtask

   task automatic test_reset_mid_frame();
      int fe0 = fe_cnt;
      int ov0 = ov_cnt;
      rx = 1'b0;
      repeat (P) @(negedge clk);
      rx = 1'b1;
      repeat (4 * P + 400) @(negedge clk);
      reset_n = 1'b0;
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      n_cmp++;
      if (read_valid !== 1'b0 || fe_cnt != fe0 || ov_cnt != ov0) begin
         n_fail++; $display("FAIL midreset_abandon got v=%b fe=%0d ov=%0d want 0 0 0",
                            read_valid, fe_cnt - fe0, ov_cnt - ov0);
      end
      send_frame(8'h81, P, 1'b1);
      n_cmp++;
      if (read_valid !== 1'b1 || read_data !== 8'h81) begin
         n_fail++; $display("FAIL midreset_next got v=%b d=%h want 1 81", read_valid, read_data);
      end
      n_cmp++;
      if (fe_cnt != fe0 || ov_cnt != ov0) begin
         n_fail++; $display("FAIL midreset_flags got fe=%0d ov=%0d want 0 0", fe_cnt - fe0,
                            ov_cnt - ov0);
      end
      consume();
   endtask

   task automatic test_baud_tolerance();
      send_frame(8'h00, 851, 1'b1);
      n_cmp++;
      if (read_valid !== 1'b1 || read_data !== 8'h00) begin
         n_fail++; $display("FAIL baud_slow_00 got v=%b d=%h want 1 00", read_valid, read_data);
      end
      consume();
      send_frame(8'hFF, 885, 1'b1);
      n_cmp++;
      if (read_valid !== 1'b1 || read_data !== 8'hFF) begin
         n_fail++; $display("FAIL baud_fast_ff got v=%b d=%h want 1 ff", read_valid, read_data);
      end
      consume();
   endtask

   initial begin
      reset_n  = 1'b0;
      rx       = 1'b1;
      read_ack = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_glitch();
      test_framing();
      test_back_to_back();
      test_reset_mid_frame();
      test_baud_tolerance();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
